// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down counter with runtime modulus (limit+1), runtime step,
// synchronous load and a registered wrap pulse.
// Optional feature macro: MOD_COUNTER_SAT_EN (sat input selects saturate vs. wrap;
// when undefined the counter always wraps and sat is ignored).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   load_n     active-low synchronous load of data_load (clamped to limit)
//   ce         count enable
//   up_down    1 = up, 0 = down
//   sat        1 = saturate, 0 = wrap (only with MOD_COUNTER_SAT_EN)
//   step       advance amount, 0 = hold
//   limit      inclusive upper bound of the range 0..limit
//   data_load  load value
//   count_out  registered count
//   max_count  count_out == limit
//   zero       count_out == 0
//   wrap       one-cycle pulse aligned with the count produced by a boundary crossing
module mod_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic              ce,
    input  logic              up_down,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  data_load,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              wrap
);
    localparam logic [WIDTH:0] one = 1;

    logic             sat_eff;
    logic [WIDTH:0]   cnt_x, lim_x, m, stp, up_sum, up_red, up_wr, dn_wr, nxt;
    logic             oor, up_over, dn_under, crs;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_eff = sat;
`else
    assign sat_eff = sat & 1'b0;
`endif

    // One extra bit of headroom so count+step and count+M never overflow.
    assign cnt_x = {1'b0, count_out};
    assign lim_x = {1'b0, limit};
    assign m     = lim_x + one;
    assign stp   = (WIDTH+1)'(step);

    always_comb begin
        oor      = cnt_x > lim_x;
        up_sum   = cnt_x + stp;
        up_over  = up_sum > lim_x;
        dn_under = stp > cnt_x;
        up_red   = up_sum - m;
        // A step larger than the modulus cannot be folded once; pin to the far end.
        up_wr    = (up_red > lim_x) ? '0 : up_red;
        dn_wr    = (stp > m) ? lim_x : cnt_x + m - stp;
        // Out-of-range recovery takes precedence over everything, including step=0.
        nxt = oor ? (sat_eff ? lim_x : '0) :
              (step == '0) ? cnt_x :
              up_down ? (up_over ? (sat_eff ? lim_x : up_wr) : up_sum) :
                        (dn_under ? (sat_eff ? '0 : dn_wr) : cnt_x - stp);
        crs = oor || ((step != '0) && (up_down ? up_over : dn_under));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_out <= '0;
            wrap      <= 1'b0;
        end else if (!load_n) begin
            count_out <= (data_load > limit) ? limit : data_load;
            wrap      <= 1'b0;
        end else if (ce) begin
            count_out <= nxt[WIDTH-1:0];
            wrap      <= crs;
        end else begin
            wrap      <= 1'b0;
        end
    end

    assign max_count = count_out == limit;
    assign zero      = count_out == '0;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench comparing mod_updown_counter against an integer reference model.
module tb_mod_updown_counter;
    localparam int W = 4;
    localparam int SW = 4;

`ifdef MOD_COUNTER_SAT_EN
    localparam bit sat_en = 1'b1;
`else
    localparam bit sat_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, load_n, ce, up_down, sat;
    logic [SW-1:0] step;
    logic [W-1:0]  limit, data_load, count_out;
    logic          max_count, zero, wrap;

    mod_updown_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .ce(ce), .up_down(up_down),
        .sat(sat), .step(step), .limit(limit), .data_load(data_load),
        .count_out(count_out), .max_count(max_count), .zero(zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit w;
        bit mx;
        bit z;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mcnt = 0;
    bit   done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: counting on plain integers over the range 0..lim, modulus lim+1.
    task automatic drive(input bit r, input bit ld, input bit c, input bit u, input bit s,
                         input int st, input int lim, input int dl);
        exp_t e;
        int   mm;
        bit   sm;
        @(negedge clk);
        rst_n = r; load_n = ld; ce = c; up_down = u; sat = s;
        step = SW'(st); limit = W'(lim); data_load = W'(dl);
        mm = lim + 1;
        sm = sat_en && s;
        e.w = 1'b0;
        if (!r) mcnt = 0;
        else if (!ld) mcnt = (dl > lim) ? lim : dl;
        else if (c) begin
            if (mcnt > lim) begin
                mcnt = sm ? lim : 0;
                e.w = 1'b1;
            end else if (st == 0) begin
            end else if (u) begin
                if (mcnt + st <= lim) mcnt = mcnt + st;
                else begin
                    e.w = 1'b1;
                    mcnt = sm ? lim : ((mcnt + st - mm > lim) ? 0 : mcnt + st - mm);
                end
            end else begin
                if (st <= mcnt) mcnt = mcnt - st;
                else begin
                    e.w = 1'b1;
                    mcnt = sm ? 0 : ((st > mm) ? lim : mcnt + mm - st);
                end
            end
        end
        e.cnt = mcnt;
        e.mx = (mcnt == lim);
        e.z = (mcnt == 0);
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("count_out", int'(count_out), e.cnt);
            check("wrap", int'(wrap), int'(e.w));
            check("max_count", int'(max_count), int'(e.mx));
            check("zero", int'(zero), int'(e.z));
        end
    end

    initial begin
        int lim;
        rst_n = 1'b0; load_n = 1'b1; ce = 1'b0; up_down = 1'b1; sat = 1'b0;
        step = '0; limit = 4'd9; data_load = '0;
        // reset overrides load and count
        drive(0, 0, 1, 1, 0, 3, 9, 9);
        // wrap up: 8 +3 -> 1 (wrap), then 4
        drive(1, 0, 0, 1, 0, 3, 9, 8);
        drive(1, 1, 1, 1, 0, 3, 9, 0);
        drive(1, 1, 1, 1, 0, 3, 9, 0);
        // wrap down: 1 -2 -> 9
        drive(1, 0, 0, 0, 0, 2, 9, 1);
        drive(1, 1, 1, 0, 0, 2, 9, 0);
        // saturate stimulus (behaviour depends on macro)
        drive(1, 0, 0, 1, 1, 3, 9, 8);
        drive(1, 1, 1, 1, 1, 3, 9, 0);
        drive(1, 1, 1, 1, 1, 3, 9, 0);
        // load clamp, lower limit, recover out-of-range
        drive(1, 0, 0, 1, 0, 1, 9, 14);
        drive(1, 1, 0, 1, 0, 1, 5, 0);
        drive(1, 1, 1, 1, 0, 1, 5, 0);
        // step 0 hold, load beats ce
        drive(1, 1, 1, 1, 0, 0, 5, 0);
        drive(1, 0, 1, 1, 0, 2, 5, 3);
        // limit = 0 and step > modulus corners
        drive(1, 1, 1, 1, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0, 7, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 3, 2);
        drive(1, 1, 1, 1, 0, 15, 3, 0);
        drive(1, 1, 1, 0, 0, 15, 3, 0);
        drive(1, 1, 1, 0, 0, 4, 3, 0);
        lim = 9;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) lim = $urandom_range(15);
            drive($urandom_range(49) != 0, $urandom_range(7) != 0, $urandom_range(3) != 0,
                  1'($urandom), 1'($urandom), $urandom_range(15), lim, $urandom_range(15));
        end
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
